// File: rtl/bird_pkg.sv
// Shared bird types and default geometry/physics constants for the bird, pipe and collision blocks.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int unsigned CW_DEF       = 11;
  localparam int unsigned VW_DEF       = 8;
  localparam int unsigned BIRD_X_DEF   = 400;
  localparam int unsigned BIRD_W_DEF   = 32;
  localparam int unsigned BIRD_H_DEF   = 24;
  localparam int unsigned Y_START_DEF  = 288;
  localparam int unsigned SCREEN_H_DEF = 600;
  localparam int unsigned GRAVITY_DEF  = 1;
  localparam int          FLAP_VEL_DEF = -9;
  localparam int unsigned VMAX_DEF     = 12;
  localparam logic [11:0] BIRD_RGB_DEF = 12'h0F0;
  localparam logic [11:0] DEAD_RGB_DEF = 12'hF00;

endpackage

// File: rtl/vga_if.sv
// VGA raster position as seen by the sprite renderers.
interface vga_if;
  import bird_pkg::*;

  logic [CW_DEF-1:0] hcount;
  logic [CW_DEF-1:0] vcount;

  modport in  (input hcount, input vcount);
  modport out (output hcount, output vcount);
endinterface

// File: rtl/bird_physics.sv
// Frame-synchronous bird physics: flap edge detect, per-frame tick, gravity, ceiling clamp, ground hit.
module bird_physics
  import bird_pkg::*;
#(
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned VW       = VW_DEF,
  parameter int unsigned BIRD_H   = BIRD_H_DEF,
  parameter int unsigned Y_START  = Y_START_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned GRAVITY  = GRAVITY_DEF,
  parameter int          FLAP_VEL = FLAP_VEL_DEF,
  parameter int unsigned VMAX     = VMAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_game_rst,
  input  logic          i_mouse_left,
  input  logic [CW-1:0] i_hcount,
  input  logic [CW-1:0] i_vcount,
  output logic [CW-1:0] o_bird_y,
  output logic          o_dead
);

  localparam int unsigned YW = CW + 1;
  localparam int unsigned SW = VW + 1;

  state_t                r_state, w_state_n;
  logic [CW-1:0]         r_bird_y, w_bird_y_n;
  logic signed [VW-1:0]  r_vel, w_vel_n;
  logic                  r_dead, w_dead_n;
  logic                  r_flap_pend, w_flap_pend_n;
  logic                  r_mouse_q;
  logic                  w_tick, w_rise, w_apply;
  logic signed [SW-1:0]  w_vel_grav;
  logic signed [VW-1:0]  w_vel_cand;
  logic signed [YW-1:0]  w_y_cand;
  logic [YW-1:0]         w_y_bottom;
  logic                  w_ceiling, w_ground;

  assign w_tick = (i_vcount == CW'(SCREEN_H)) && (i_hcount == '0);
  assign w_rise = i_mouse_left & ~r_mouse_q;

  // Candidate motion for this tick; only committed when w_apply is set.
  assign w_vel_grav = SW'(r_vel) + $signed(SW'(GRAVITY));
  assign w_vel_cand = r_flap_pend ? VW'(FLAP_VEL)
                    : (w_vel_grav > $signed(SW'(VMAX))) ? VW'(VMAX) : VW'(w_vel_grav);
  assign w_y_cand   = $signed({1'b0, r_bird_y}) + YW'(w_vel_cand);
  assign w_y_bottom = $unsigned(w_y_cand) + YW'(BIRD_H);
  assign w_ceiling  = w_y_cand[YW-1];
  assign w_ground   = w_y_bottom >= YW'(SCREEN_H);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bird_y    <= CW'(Y_START);
      r_vel       <= '0;
      r_dead      <= 1'b0;
      r_flap_pend <= 1'b0;
      r_mouse_q   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_bird_y    <= w_bird_y_n;
      r_vel       <= w_vel_n;
      r_dead      <= w_dead_n;
      r_flap_pend <= w_flap_pend_n;
      r_mouse_q   <= i_mouse_left;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_bird_y_n    = r_bird_y;
    w_vel_n       = r_vel;
    w_dead_n      = r_dead;
    w_flap_pend_n = r_flap_pend | w_rise;
    w_apply       = 1'b0;

    case (r_state)
      IDLE: if (w_tick) begin
        w_flap_pend_n = w_rise;
        w_apply       = r_flap_pend;
      end
      FLY: if (w_tick) begin
        w_flap_pend_n = w_rise;
        w_apply       = 1'b1;
      end
      DEAD:    w_flap_pend_n = 1'b0;
      default: w_state_n     = IDLE;
    endcase

    if (w_apply) begin
      w_state_n = FLY;
      if (w_ceiling) begin
        w_bird_y_n = '0;
        w_vel_n    = '0;
      end else if (w_ground) begin
        w_bird_y_n = CW'(SCREEN_H - BIRD_H);
        w_vel_n    = '0;
        w_dead_n   = 1'b1;
        w_state_n  = DEAD;
      end else begin
        w_bird_y_n = CW'(w_y_cand);
        w_vel_n    = w_vel_cand;
      end
    end

    // Restart overrides everything, including a coincident tick.
    if (i_game_rst) begin
      w_state_n     = IDLE;
      w_bird_y_n    = CW'(Y_START);
      w_vel_n       = '0;
      w_dead_n      = 1'b0;
      w_flap_pend_n = 1'b0;
    end
  end

  assign o_bird_y = r_bird_y;
  assign o_dead   = r_dead;

endmodule

// File: rtl/draw_bird.sv
// Bird sprite: physics instance plus one-cycle registered pixel compare and colour select.
module draw_bird
  import bird_pkg::*;
#(
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned VW       = VW_DEF,
  parameter int unsigned BIRD_X   = BIRD_X_DEF,
  parameter int unsigned BIRD_W   = BIRD_W_DEF,
  parameter int unsigned BIRD_H   = BIRD_H_DEF,
  parameter int unsigned Y_START  = Y_START_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned GRAVITY  = GRAVITY_DEF,
  parameter int          FLAP_VEL = FLAP_VEL_DEF,
  parameter int unsigned VMAX     = VMAX_DEF,
  parameter logic [11:0] BIRD_RGB = BIRD_RGB_DEF,
  parameter logic [11:0] DEAD_RGB = DEAD_RGB_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_rst,
  input  logic          mouse_left,
  vga_if.in             vin,
  output logic [11:0]   rgb,
  output logic          valid,
  output logic [CW-1:0] bird_y,
  output logic          dead
);

  localparam int unsigned YW = CW + 1;

  logic [CW-1:0] w_bird_y;
  logic          w_dead;
  logic [YW-1:0] w_hx, w_vy, w_top, w_bot;
  logic          w_hit;
  logic [11:0]   r_rgb;
  logic          r_valid;

  bird_physics #(
    .CW(CW), .VW(VW), .BIRD_H(BIRD_H), .Y_START(Y_START), .SCREEN_H(SCREEN_H),
    .GRAVITY(GRAVITY), .FLAP_VEL(FLAP_VEL), .VMAX(VMAX)
  ) u_phys (
    .clk          (clk),
    .rst          (rst),
    .i_game_rst   (game_rst),
    .i_mouse_left (mouse_left),
    .i_hcount     (vin.hcount),
    .i_vcount     (vin.vcount),
    .o_bird_y     (w_bird_y),
    .o_dead       (w_dead)
  );

  // One extra bit so the bottom edge never wraps.
  assign w_hx  = {1'b0, vin.hcount};
  assign w_vy  = {1'b0, vin.vcount};
  assign w_top = {1'b0, w_bird_y};
  assign w_bot = w_top + YW'(BIRD_H);
  assign w_hit = (w_hx >= YW'(BIRD_X)) && (w_hx < YW'(BIRD_X + BIRD_W)) &&
                 (w_vy >= w_top) && (w_vy < w_bot);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_rgb   <= 12'h000;
    end else begin
      r_valid <= w_hit;
      r_rgb   <= w_hit ? (w_dead ? DEAD_RGB : BIRD_RGB) : 12'h000;
    end
  end

  assign rgb    = r_rgb;
  assign valid  = r_valid;
  assign bird_y = w_bird_y;
  assign dead   = w_dead;

endmodule

// File: tb/tb_draw_bird.sv
// Randomised self-checking bench for draw_bird against a frame-level bird model.
module tb_draw_bird;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_rst;
  logic        mouse_left;
  logic [11:0] rgb;
  logic        valid;
  logic [10:0] bird_y;
  logic        dead;

  int checks = 0;
  int errors = 0;

  // Model: bird position/velocity per frame, plus mode flags.
  int m_y, m_vel;
  bit m_fly, m_dead, m_flap;

  vga_if vif();

  draw_bird dut (
    .clk        (clk),
    .rst        (rst),
    .game_rst   (game_rst),
    .mouse_left (mouse_left),
    .vin        (vif),
    .rgb        (rgb),
    .valid      (valid),
    .bird_y     (bird_y),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic bit exp_valid(input int h, input int v);
    return (h >= 400) && (h < 432) && (v >= m_y) && (v < m_y + 24);
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v);
    if (!exp_valid(h, v)) return 12'h000;
    return m_dead ? 12'hF00 : 12'h0F0;
  endfunction

  task automatic model_reset();
    m_y = 288; m_vel = 0; m_fly = 0; m_dead = 0; m_flap = 0;
  endtask

  task automatic model_tick();
    int v, yn;
    if (m_dead) begin m_flap = 0; return; end
    if (!m_fly && !m_flap) return;
    v = m_flap ? -9 : ((m_vel + 1 > 12) ? 12 : m_vel + 1);
    m_flap = 0;
    m_fly  = 1;
    yn = m_y + v;
    if (yn < 0) begin
      m_y = 0; m_vel = 0;
    end else if (yn + 24 >= 600) begin
      m_y = 576; m_vel = 0; m_dead = 1;
    end else begin
      m_y = yn; m_vel = v;
    end
  endtask

  task automatic cyc(input int h, input int v);
    vif.hcount = 11'(h);
    vif.vcount = 11'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc($urandom_range(0, 1055), $urandom_range(0, 599));
  endtask

  task automatic tick();
    cyc(0, 600);
    model_tick();
  endtask

  task automatic click();
    mouse_left = 1'b1;
    idle_cyc();
    mouse_left = 1'b0;
    idle_cyc();
    if (!m_dead) m_flap = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0; game_rst = 1'b0; mouse_left = 1'b0;
    vif.hcount = '0; vif.vcount = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    cyc(405, 290);
    checks++;
    if (bird_y !== 11'd288) begin errors++; $display("FAIL reset_bird_y got %0d expected 288", bird_y); end
    checks++;
    if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead got %0b expected 0", dead); end
    checks++;
    if (rgb !== exp_rgb(405, 290) || valid !== 1'b1)
      begin errors++; $display("FAIL reset_first_pixel got rgb=%h valid=%0b expected rgb=%h valid=1", rgb, valid, exp_rgb(405, 290)); end
  endtask

  task automatic test_idle();
    int hs[8] = '{399, 400, 431, 432, 400, 400, 431, 415};
    int vs[8] = '{288, 288, 311, 311, 287, 312, 288, 300};
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 8; i++) begin
        cyc(hs[i], vs[i]);
        checks++;
        if (rgb !== exp_rgb(hs[i], vs[i]) || valid !== exp_valid(hs[i], vs[i]))
          begin errors++; $display("FAIL idle_edge f%0d (%0d,%0d) got rgb=%h valid=%0b expected rgb=%h valid=%0b", f, hs[i], vs[i], rgb, valid, exp_rgb(hs[i], vs[i]), exp_valid(hs[i], vs[i])); end
      end
      for (int i = 0; i < 6; i++) begin
        int h, v;
        h = $urandom_range(390, 440);
        v = $urandom_range(278, 320);
        cyc(h, v);
        checks++;
        if (rgb !== exp_rgb(h, v) || valid !== exp_valid(h, v))
          begin errors++; $display("FAIL idle_rand (%0d,%0d) got rgb=%h valid=%0b expected rgb=%h", h, v, rgb, valid, exp_rgb(h, v)); end
      end
      tick();
      checks++;
      if (bird_y !== 11'd288) begin errors++; $display("FAIL idle_bird_y f%0d got %0d expected 288", f, bird_y); end
    end
  endtask

  task automatic test_flap();
    int exp_y[3] = '{279, 271, 264};
    click();
    repeat ($urandom_range(1, 6)) idle_cyc();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bird_y !== 11'(exp_y[i]) || 11'(m_y) !== 11'(exp_y[i]))
        begin errors++; $display("FAIL flap_y[%0d] got %0d expected %0d", i, bird_y, exp_y[i]); end
      repeat ($urandom_range(1, 4)) idle_cyc();
    end
  endtask

  task automatic test_ceiling();
    int clamps = 0;
    for (int i = 0; i < 40 && clamps < 2; i++) begin
      click();
      tick();
      if (m_y == 0) clamps++;
      checks++;
      if (bird_y !== 11'(m_y) || dead !== 1'b0)
        begin errors++; $display("FAIL ceiling_y[%0d] got y=%0d dead=%0b expected y=%0d dead=0", i, bird_y, dead, m_y); end
    end
    tick();
    checks++;
    if (bird_y !== 11'd1) begin errors++; $display("FAIL ceiling_vel_zero got %0d expected 1", bird_y); end
  endtask

  task automatic test_multi_click();
    int prev, at_max;
    prev = m_y;
    for (int i = 0; i < 3; i++) begin
      click();
      repeat ($urandom_range(0, 3)) idle_cyc();
    end
    tick();
    checks++;
    if (bird_y !== 11'(m_y)) begin errors++; $display("FAIL multi_click_y got %0d expected %0d (from %0d)", bird_y, m_y, prev); end
    at_max = 0;
    for (int i = 0; i < 40 && at_max < 3; i++) begin
      prev = int'(bird_y);
      tick();
      checks++;
      if (bird_y !== 11'(m_y)) begin errors++; $display("FAIL fall_y[%0d] got %0d expected %0d", i, bird_y, m_y); end
      if (m_vel == 12) begin
        at_max++;
        checks++;
        if (int'(bird_y) - prev !== 12) begin errors++; $display("FAIL terminal_step got %0d expected 12", int'(bird_y) - prev); end
      end
    end
  endtask

  task automatic test_ground();
    for (int i = 0; i < 100 && !m_dead; i++) begin
      repeat ($urandom_range(1, 3)) idle_cyc();
      checks++;
      if (dead !== 1'b0) begin errors++; $display("FAIL ground_early_dead[%0d] got 1 expected 0", i); end
      tick();
      checks++;
      if (bird_y !== 11'(m_y) || dead !== m_dead)
        begin errors++; $display("FAIL ground_y[%0d] got y=%0d dead=%0b expected y=%0d dead=%0b", i, bird_y, dead, m_y, m_dead); end
    end
    checks++;
    if (bird_y !== 11'd576 || dead !== 1'b1) begin errors++; $display("FAIL ground_final got y=%0d dead=%0b expected 576/1", bird_y, dead); end
    cyc(400, 576);
    checks++;
    if (rgb !== 12'hF00 || valid !== 1'b1) begin errors++; $display("FAIL dead_rgb got %h valid=%0b expected F00/1", rgb, valid); end
    cyc(432, 580);
    checks++;
    if (rgb !== 12'h000 || valid !== 1'b0) begin errors++; $display("FAIL dead_outside got %h valid=%0b expected 000/0", rgb, valid); end
    click(); click();
    tick(); tick();
    checks++;
    if (bird_y !== 11'd576 || dead !== 1'b1) begin errors++; $display("FAIL dead_frozen got y=%0d dead=%0b expected 576/1", bird_y, dead); end
  endtask

  task automatic test_game_rst_tick();
    game_rst = 1'b1;
    cyc(0, 600);
    game_rst = 1'b0;
    model_reset();
    checks++;
    if (bird_y !== 11'd288 || dead !== 1'b0) begin errors++; $display("FAIL grst_tick got y=%0d dead=%0b expected 288/0", bird_y, dead); end
    tick(); tick();
    checks++;
    if (bird_y !== 11'd288) begin errors++; $display("FAIL grst_idle got %0d expected 288", bird_y); end
    cyc(400, 288);
    checks++;
    if (rgb !== 12'h0F0 || valid !== 1'b1) begin errors++; $display("FAIL grst_rgb got %h valid=%0b expected 0F0/1", rgb, valid); end
  endtask

  task automatic test_async_reset();
    click();
    tick();
    checks++;
    if (bird_y !== 11'd279) begin errors++; $display("FAIL pre_rst_y got %0d expected 279", bird_y); end
    cyc(410, 290);
    checks++;
    if (valid !== 1'b1 || rgb !== 12'h0F0) begin errors++; $display("FAIL pre_rst_pixel got %h valid=%0b expected 0F0/1", rgb, valid); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (rgb !== 12'h000 || valid !== 1'b0 || bird_y !== 11'd288 || dead !== 1'b0)
      begin errors++; $display("FAIL async_rst got rgb=%h valid=%0b y=%0d dead=%0b expected 000/0/288/0", rgb, valid, bird_y, dead); end
    @(posedge clk);
    #2 rst = 1'b1;
    cyc(410, 290);
    checks++;
    if (rgb !== exp_rgb(410, 290) || valid !== exp_valid(410, 290))
      begin errors++; $display("FAIL post_rst_pixel got %h valid=%0b expected %h", rgb, valid, exp_rgb(410, 290)); end
    tick();
    checks++;
    if (bird_y !== 11'd288) begin errors++; $display("FAIL post_rst_idle got %0d expected 288", bird_y); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_flap();
    test_ceiling();
    test_multi_click();
    test_ground();
    test_game_rst_tick();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
